program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, program-counter and bus width in bits (legal range 4..32).
REQ-002 SHALL have parameter DEPTH, default 8, return-stack entries (legal range 2..64, power of two not required).
REQ-003 SHALL have parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port increment  input  1  PC <= PC+1.
REQ-007 SHALL have port load  input  1  absolute jump, PC <= bus_in.
REQ-008 SHALL have port branch  input  1  relative jump, PC <= PC + signed(bus_in).
REQ-009 SHALL have port call  input  1  push PC+1, PC <= bus_in.
REQ-010 SHALL have port ret  input  1  PC <= top of stack, pop.
REQ-011 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-012 SHALL have port bus_in  input  WIDTH  jump target or signed offset.
REQ-013 SHALL have port enable  input  1  drives PC onto bus_out.
REQ-014 SHALL have port bus_out  output  WIDTH  PC when enable=1, else all-Z.
REQ-015 SHALL have port pc_q  output  WIDTH  PC, always driven.
REQ-016 SHALL have port sp  output  $clog2(DEPTH+1)  current stack occupancy, 0..DEPTH.
REQ-017 SHALL have ports ovf_err and unf_err  output  1 each  sticky stack overflow and underflow flags.

Function
REQ-018 SHALL evaluate at most one operation per rising clk edge, with fixed priority load > call > ret > branch > increment; lower-priority requests in the same cycle SHALL be ignored.
REQ-019 SHALL hold PC, stack and sp unchanged when no operation is asserted.
REQ-020 SHALL perform all PC arithmetic modulo 2^WIDTH: increment from all-ones wraps to 0; branch offsets are two's complement and wrap in both directions.
REQ-021 SHALL make every operation take effect on pc_q in the cycle after the edge that samples it (latency 1); bus_out SHALL follow pc_q combinationally.
REQ-022 On call with sp<DEPTH, SHALL write (PC+1) mod 2^WIDTH to stack[sp], increment sp and set PC <= bus_in in the same edge.
REQ-023 On call with sp==DEPTH, SHALL leave PC, stack and sp unchanged and set ovf_err.
REQ-024 On ret with sp>0, SHALL set PC <= stack[sp-1] and decrement sp.
REQ-025 On ret with sp==0, SHALL leave PC and sp unchanged and set unf_err.
REQ-026 SHALL keep ovf_err and unf_err set until clr_err or reset; clr_err SHALL take priority over a same-cycle set.
REQ-027 SHALL ensure clr_err does not affect PC, stack or sp.
REQ-028 SHALL drive bus_out to high impedance on every bit whenever enable=0, including during reset.

Reset
REQ-029 On reset assertion, SHALL immediately set PC=RESET_VEC, sp=0, ovf_err=0 and unf_err=0, independent of clk.
REQ-030 SHALL ignore all operation inputs while reset is low; a mid-call or mid-ret reset SHALL discard the operation entirely.
REQ-031 SHALL leave stack entry contents undefined after reset; they SHALL NOT be readable except through ret after a push.

Structure
REQ-032 SHALL place the operation-priority encoding (op_none, op_inc, op_branch, op_ret, op_call, op_load) as named constants in shared package seq_pkg.
REQ-033 SHALL implement the return stack as sub-module pc_return_stack (parameters WIDTH, DEPTH; push, pop, data in, top out, count, full, empty).
REQ-034 SHALL contain exactly one clocked process for PC and error flags, plus the tristate assignment.

Verification
REQ-035 Reset, then 3 increment cycles with enable=1 -> bus_out 0x0000, 0x0001, 0x0002, 0x0003; enable=0 -> bus_out all-Z.
REQ-036 PC=0xFFFF, increment -> PC=0x0000; PC=0x0002, branch with bus_in=0xFFFC -> PC=0xFFFE.
REQ-037 PC=0x0010, call 0x0100, call 0x0200, ret, ret -> PC 0x0100, 0x0200, 0x0101, 0x0011; sp 1,2,1,0.
REQ-038 Fill stack to DEPTH=8, then a 9th call -> PC and sp=8 unchanged, ovf_err=1; ret at sp=0 -> unf_err=1; clr_err -> both flags 0.
REQ-039 load=1 and increment=1 with bus_in=0x0040 -> PC=0x0040 only; call and ret together -> call wins.
REQ-040 Assert reset mid-sequence with sp=3 and a call pending -> PC=RESET_VEC and sp=0 immediately, before the next edge.

Source files
------------

// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the program sequencer.
//   op_e      : operation codes, enumerated in ascending priority order.
//   decode_op : reduces the raw request lines to the single winning operation.
// ----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [2:0] {
        op_none   = 3'd0,
        op_inc    = 3'd1,
        op_branch = 3'd2,
        op_ret    = 3'd3,
        op_call   = 3'd4,
        op_load   = 3'd5
    } op_e;

    // Fixed priority: load > call > ret > branch > increment.
    function automatic op_e decode_op(
        input logic i_load,
        input logic i_call,
        input logic i_ret,
        input logic i_branch,
        input logic i_inc
    );
        if (i_load)   return op_load;
        if (i_call)   return op_call;
        if (i_ret)    return op_ret;
        if (i_branch) return op_branch;
        if (i_inc)    return op_inc;
        return op_none;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// ----------------------------------------------------------------------------
// pc_return_stack
// LIFO of return addresses for the program sequencer.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (clears occupancy only)
//   i_push   : write i_din at the current top and grow by one (ignored if full)
//   i_pop    : shrink by one (ignored if empty)
//   i_din    : address to push
//   o_top    : most recently pushed entry (0 when empty)
//   o_count  : occupancy, 0..DEPTH
//   o_full   : occupancy == DEPTH
//   o_empty  : occupancy == 0
// Entry storage is not reset; an entry is only observable after it was pushed.
// ----------------------------------------------------------------------------
module pc_return_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [WIDTH-1:0]               i_din,
    output logic [WIDTH-1:0]               o_top,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic                           o_full,
    output logic                           o_empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_m1;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_count_m1 = r_count - CW'(1);
    assign w_wr_idx   = AW'(r_count);
    assign w_rd_idx   = AW'(w_count_m1);

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    // Read index is out of range when empty, so the output is forced to 0.
    assign o_top   = o_empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_count <= r_count + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= w_count_m1;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// ----------------------------------------------------------------------------
// program_sequencer
// Program counter with absolute/relative jumps, call/return stack and sticky
// stack error flags. One operation per edge, result visible one cycle later.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   increment  : PC <= PC + 1
//   load       : PC <= bus_in
//   branch     : PC <= PC + signed(bus_in)
//   call       : push PC + 1, PC <= bus_in (sets ovf_err when stack full)
//   ret        : PC <= popped address (sets unf_err when stack empty)
//   clr_err    : clears ovf_err / unf_err, wins over a same-cycle set
//   bus_in     : jump target or two's-complement offset
//   enable     : drives PC onto bus_out, otherwise bus_out floats
//   bus_out    : PC or high impedance
//   pc_q       : PC, always driven
//   sp         : return-stack occupancy, 0..DEPTH
//   ovf_err    : sticky overflow flag
//   unf_err    : sticky underflow flag
// ----------------------------------------------------------------------------
module program_sequencer
    import seq_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          DEPTH     = 8,
    parameter int unsigned RESET_VEC = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         increment,
    input  logic                         load,
    input  logic                         branch,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         clr_err,
    input  logic [WIDTH-1:0]             bus_in,
    input  logic                         enable,
    output logic [WIDTH-1:0]             bus_out,
    output logic [WIDTH-1:0]             pc_q,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         ovf_err,
    output logic                         unf_err
);

    op_e                     w_op;
    logic [WIDTH-1:0]        r_pc;
    logic                    r_ovf;
    logic                    r_unf;
    logic [WIDTH-1:0]        w_pc_next;
    logic [WIDTH-1:0]        w_pc_inc;
    logic signed [WIDTH-1:0] w_offset;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_set_ovf;
    logic                    w_set_unf;
    logic [WIDTH-1:0]        w_top;
    logic                    w_full;
    logic                    w_empty;

    assign w_op     = decode_op(load, call, ret, branch, increment);
    assign w_pc_inc = r_pc + WIDTH'(1);
    assign w_offset = bus_in;

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_pc_inc),
        .o_top   (w_top),
        .o_count (sp),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        unique case (w_op)
            op_load: w_pc_next = bus_in;
            op_call: begin
                if (!w_full) begin
                    w_push    = 1'b1;
                    w_pc_next = bus_in;
                end else begin
                    w_set_ovf = 1'b1;
                end
            end
            op_ret: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_pc_next = w_top;
                end else begin
                    w_set_unf = 1'b1;
                end
            end
            // Same-width add wraps in both directions for a signed offset.
            op_branch: w_pc_next = r_pc + $unsigned(w_offset);
            op_inc:    w_pc_next = w_pc_inc;
            default:   w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= WIDTH'(RESET_VEC);
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (clr_err) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (w_set_ovf) r_ovf <= 1'b1;
                if (w_set_unf) r_unf <= 1'b1;
            end
        end
    end

    assign pc_q    = r_pc;
    assign ovf_err = r_ovf;
    assign unf_err = r_unf;
    assign bus_out = enable ? r_pc : {WIDTH{1'bz}};

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        increment, load, branch, call, ret, clr_err, enable;
    logic [15:0] bus_in;
    wire  [15:0] bus_out;
    logic [15:0] pc_q;
    logic [3:0]  sp;
    logic        ovf_err, unf_err;

    int n_checks = 0;
    int n_errors = 0;

    program_sequencer #(.WIDTH(16), .DEPTH(8), .RESET_VEC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .increment (increment),
        .load      (load),
        .branch    (branch),
        .call      (call),
        .ret       (ret),
        .clr_err   (clr_err),
        .bus_in    (bus_in),
        .enable    (enable),
        .bus_out   (bus_out),
        .pc_q      (pc_q),
        .sp        (sp),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_ops();
        increment = 0; load = 0; branch = 0; call = 0; ret = 0; clr_err = 0;
    endtask

    // Apply the currently driven requests for exactly one edge, then sample.
    task automatic step();
        @(posedge clk);
        #1;
        clear_ops();
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1; bus_in = v; step();
    endtask

    task automatic do_call(input logic [15:0] v);
        call = 1; bus_in = v; step();
    endtask

    task automatic do_ret();
        ret = 1; step();
    endtask

    logic [15:0] zval;

    initial begin
        zval = 16'hzzzz;
        clear_ops();
        bus_in = 16'h0;
        enable = 1;
        reset  = 0;
        #2;
        check("rst_pc", pc_q, 32'h0);
        check("rst_sp", sp, 32'h0);
        check("rst_flags", {ovf_err, unf_err}, 32'h0);
        check("rst_bus", bus_out, 32'h0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        // Increment sequence with bus observation.
        increment = 1; step(); check("inc1_bus", bus_out, 32'h0001);
        increment = 1; step(); check("inc2_bus", bus_out, 32'h0002);
        increment = 1; step(); check("inc3_bus", bus_out, 32'h0003);
        enable = 0; #1;
        check("bus_z", (bus_out === zval), 32'h1);
        enable = 1;

        // Wrap-around arithmetic.
        do_load(16'hFFFF); check("load_ffff", pc_q, 32'hFFFF);
        increment = 1; step(); check("inc_wrap", pc_q, 32'h0000);
        do_load(16'h0002);
        branch = 1; bus_in = 16'hFFFC; step(); check("branch_neg", pc_q, 32'hFFFE);
        branch = 1; bus_in = 16'h0005; step(); check("branch_pos_wrap", pc_q, 32'h0003);

        // Nested call / return.
        do_load(16'h0010);
        do_call(16'h0100); check("call1_pc", pc_q, 32'h0100); check("call1_sp", sp, 32'd1);
        do_call(16'h0200); check("call2_pc", pc_q, 32'h0200); check("call2_sp", sp, 32'd2);
        do_ret();          check("ret1_pc", pc_q, 32'h0101);  check("ret1_sp", sp, 32'd1);
        do_ret();          check("ret2_pc", pc_q, 32'h0011);  check("ret2_sp", sp, 32'd0);
        step();            check("idle_pc", pc_q, 32'h0011);  check("idle_sp", sp, 32'd0);

        // Fill to capacity, overflow, drain, underflow, clear.
        for (int k = 0; k < 8; k++) do_call(16'h1000 + 16'(k));
        check("fill_sp", sp, 32'd8);
        check("fill_pc", pc_q, 32'h1007);
        check("fill_ovf", ovf_err, 32'h0);
        do_call(16'h5555);
        check("ovf_pc", pc_q, 32'h1007);
        check("ovf_sp", sp, 32'd8);
        check("ovf_flag", ovf_err, 32'h1);
        for (int k = 6; k >= 0; k--) begin
            do_ret();
            check("drain_pc", pc_q, 32'h1001 + 32'(k));
        end
        do_ret();
        check("drain_last_pc", pc_q, 32'h0012);
        check("drain_sp", sp, 32'd0);
        check("ovf_sticky", ovf_err, 32'h1);
        do_ret();
        check("unf_pc", pc_q, 32'h0012);
        check("unf_sp", sp, 32'd0);
        check("unf_flag", unf_err, 32'h1);
        clr_err = 1; ret = 1; step();
        check("clr_flags", {ovf_err, unf_err}, 32'h0);
        check("clr_pc", pc_q, 32'h0012);
        check("clr_sp", sp, 32'd0);

        // Priority resolution.
        load = 1; increment = 1; bus_in = 16'h0040; step();
        check("load_over_inc", pc_q, 32'h0040);
        call = 1; ret = 1; bus_in = 16'h0080; step();
        check("call_over_ret_pc", pc_q, 32'h0080);
        check("call_over_ret_sp", sp, 32'd1);
        check("call_over_ret_unf", unf_err, 32'h0);
        ret = 1; branch = 1; bus_in = 16'h0100; step();
        check("ret_over_branch", pc_q, 32'h0041);
        load = 1; call = 1; bus_in = 16'h0300; step();
        check("load_over_call_pc", pc_q, 32'h0300);
        check("load_over_call_sp", sp, 32'd0);

        // Asynchronous reset with a call pending.
        do_call(16'h0100); do_call(16'h0200); do_call(16'h0300);
        check("pre_rst_sp", sp, 32'd3);
        call = 1; bus_in = 16'h0900;
        @(negedge clk); #2;
        reset = 0; #1;
        check("async_rst_pc", pc_q, 32'h0);
        check("async_rst_sp", sp, 32'd0);
        @(posedge clk); #1;
        check("held_rst_pc", pc_q, 32'h0);
        check("held_rst_sp", sp, 32'd0);
        clear_ops();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        do_ret();
        check("post_rst_unf", unf_err, 32'h1);
        check("post_rst_pc", pc_q, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
